approx_add_pipe: RTL and testbench

- Parametrised, pipelined W-bit adder built from half/full-adder cells; next generation of the single-bit half-adder cell.
- Lower APPROX_BITS use lower-part-OR approximation (LOA); upper bits are added exactly, split into STAGES ripple slices with one register per slice.
- Valid/ready streaming interface.
- Used as the partial-product accumulation adder in the 8-bit approximate multiplier datapath, and standalone at wider widths.

---
 rtl/approx_pkg.sv | 36 +++
 rtl/approx_add_slice.sv | 23 ++
 rtl/approx_add_pipe.sv | 143 ++++++++++++++
 tb/tb_approx_add_pipe.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// Shared helpers for the pipelined LOA adder: slice geometry, legality check,
// register-layout offsets and the error-counter type.
package approx_pkg;

   localparam int ERR_W = 16;

   typedef logic [ERR_W-1:0] err_cnt_t;

   function automatic int slice_w(input int width, input int approx_bits, input int stages);
      return (width - approx_bits) / stages;
   endfunction

   function automatic bit params_ok(input int width, input int approx_bits, input int stages);
      return (width >= 4) && (approx_bits >= 0) && (approx_bits < width) &&
             ((stages == 1) || (stages == 2) || (stages == 4)) &&
             (((width - approx_bits) % stages) == 0);
   endfunction

   // Operand slices still waiting for their carry are packed per stage,
   // stage s keeping (stages-1-s) slices; this returns where stage s starts.
   function automatic int rem_off(input int s, input int sw, input int stages);
      int off;
      off = 0;
      for (int j = 0; j < s; j++) off += (stages - 1 - j) * sw;
      return off;
   endfunction

   // Completed result bits grow by one slice per stage (LOA bits included).
   function automatic int sum_off(input int s, input int k, input int sw);
      int off;
      off = 0;
      for (int j = 0; j < s; j++) off += k + (j + 1) * sw;
      return off;
   endfunction

endpackage

// File: rtl/approx_add_slice.sv
// Combinational W-bit ripple adder of full-adder cells with carry in/out.
module approx_add_slice #(
   parameter int W = 6
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   always_comb begin
      logic carry;
      s     = '0;
      carry = ci;
      for (int i = 0; i < W; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      co = carry;
   end

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined lower-part-OR approximate adder with valid/ready handshake.
// Define APPROX_ADD_ERR_MON_EN to add the exact shadow pipe and err_cnt port.
module approx_add_pipe
   import approx_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int APPROX_BITS = 4,
   parameter int STAGES      = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
`ifdef APPROX_ADD_ERR_MON_EN
   ,
   output err_cnt_t         err_cnt
`endif
);

   localparam int K      = APPROX_BITS;
   localparam int S      = slice_w(WIDTH, APPROX_BITS, STAGES);
   localparam int REMW   = S * STAGES * (STAGES - 1) / 2;
   localparam int REMW_D = (REMW > 0) ? REMW : 1;
   localparam int SUMW   = STAGES * K + S * STAGES * (STAGES + 1) / 2;

   if (!params_ok(WIDTH, APPROX_BITS, STAGES)) begin : g_bad_params
      $error("approx_add_pipe: illegal WIDTH/APPROX_BITS/STAGES combination");
   end

   logic              adv;
   logic              c0;
   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [SUMW-1:0]   sum_q, sum_d;
   logic [REMW_D-1:0] ra_q, ra_d, rb_q, rb_d;
   logic [S-1:0]      sl_a [STAGES];
   logic [S-1:0]      sl_b [STAGES];
   logic [S-1:0]      sl_s [STAGES];
   logic              sl_ci [STAGES];
   logic              sl_co [STAGES];

   // The whole pipe advances together, so backpressure can never split a transaction.
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = v_q[STAGES-1];
   assign sum       = {c_q[STAGES-1], sum_q[SUMW-1 -: WIDTH]};

   if (K > 0) begin : g_loa
      assign sum_d[K-1:0] = a[K-1:0] | b[K-1:0];
      assign c0           = a[K-1] & b[K-1];
   end else begin : g_exact
      assign c0 = 1'b0;
   end

   if (REMW == 0) begin : g_no_rem
      assign ra_d = '0;
      assign rb_d = '0;
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int SO = sum_off(s, K, S);
      localparam int DW = K + (s + 1) * S;
      localparam int RW = (STAGES - 1 - s) * S;
      localparam int RO = rem_off(s, S, STAGES);

      approx_add_slice #(.W(S)) u_slice (
         .a  (sl_a[s]),
         .b  (sl_b[s]),
         .ci (sl_ci[s]),
         .s  (sl_s[s]),
         .co (sl_co[s])
      );

      assign c_d[s]               = sl_co[s];
      assign sum_d[SO+DW-1 -: S]  = sl_s[s];

      if (s == 0) begin : g_first
         assign sl_a[s]  = a[K +: S];
         assign sl_b[s]  = b[K +: S];
         assign sl_ci[s] = c0;
         assign v_d[s]   = in_valid;
         if (RW > 0) begin : g_rem
            assign ra_d[RO +: RW] = a[WIDTH-1 -: RW];
            assign rb_d[RO +: RW] = b[WIDTH-1 -: RW];
         end
      end else begin : g_next
         localparam int PSO = sum_off(s - 1, K, S);
         localparam int PDW = K + s * S;
         localparam int PRO = rem_off(s - 1, S, STAGES);

         // Lowest waiting slice meets the carry registered by the previous stage.
         assign sl_a[s]          = ra_q[PRO +: S];
         assign sl_b[s]          = rb_q[PRO +: S];
         assign sl_ci[s]         = c_q[s-1];
         assign v_d[s]           = v_q[s-1];
         assign sum_d[SO +: PDW] = sum_q[PSO +: PDW];
         if (RW > 0) begin : g_rem
            assign ra_d[RO +: RW] = ra_q[PRO+S +: RW];
            assign rb_d[RO +: RW] = rb_q[PRO+S +: RW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q   <= '0;
         c_q   <= '0;
         sum_q <= '0;
         ra_q  <= '0;
         rb_q  <= '0;
      end else if (adv) begin
         v_q   <= v_d;
         c_q   <= c_d;
         sum_q <= sum_d;
         ra_q  <= ra_d;
         rb_q  <= rb_d;
      end
   end

`ifdef APPROX_ADD_ERR_MON_EN
   logic [WIDTH:0] ex_q [STAGES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) ex_q[i] <= '0;
         err_cnt <= '0;
      end else begin
         if (adv) begin
            ex_q[0] <= {1'b0, a} + {1'b0, b};
            for (int i = 1; i < STAGES; i++) ex_q[i] <= ex_q[i-1];
         end
         if (out_valid && out_ready && (ex_q[STAGES-1] != sum) && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed self-checking bench for approx_add_pipe (16-bit, 4 LOA bits, 2 stages).
module tb_approx_add_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] sum;
`ifdef APPROX_ADD_ERR_MON_EN
   logic [15:0] err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   approx_add_pipe #(.WIDTH(16), .APPROX_BITS(4), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
`ifdef APPROX_ADD_ERR_MON_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated transaction: result must appear two clocks after the operands are presented.
   task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [16:0] exp);
      a = va; b = vb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
      tick();
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_sum"}, {15'd0, sum}, {15'd0, exp});
      tick();
      chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {15'd0, sum}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef APPROX_ADD_ERR_MON_EN
      chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
      rst_n = 1'b1;

      run_one("v5pA", 16'h0005, 16'h000A, 17'h0000F);
      run_one("vFp1", 16'h000F, 16'h0001, 17'h0000F);
      run_one("vFFFF", 16'hFFFF, 16'hFFFF, 17'h1FFFF);
`ifdef APPROX_ADD_ERR_MON_EN
      chk("err_cnt_three", {16'd0, err_cnt}, 32'd2);
`endif

      // Back-to-back stream with a three-cycle output stall after the first result.
      a = 16'h0010; b = 16'h0020; in_valid = 1'b1;
      tick();
      a = 16'h1234; b = 16'h1111;
      tick();
      chk("st_r0_valid", {31'd0, out_valid}, 32'd1);
      chk("st_r0_sum", {15'd0, sum}, 32'h00030);
      a = 16'h8008; b = 16'h8008; out_ready = 1'b0;
      #1;
      chk("st_in_ready_low", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_stall_valid", {31'd0, out_valid}, 32'd1);
         chk("st_stall_sum", {15'd0, sum}, 32'h00030);
         chk("st_stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("st_in_ready_high", {31'd0, in_ready}, 32'd1);
      tick();
      chk("st_r1_sum", {15'd0, sum}, 32'h02345);
      a = 16'h0FF0; b = 16'h0010;
      tick();
      chk("st_r2_sum", {15'd0, sum}, 32'h10018);
      in_valid = 1'b0;
      tick();
      chk("st_r3_valid", {31'd0, out_valid}, 32'd1);
      chk("st_r3_sum", {15'd0, sum}, 32'h01000);
      tick();
      chk("st_empty", {31'd0, out_valid}, 32'd0);
`ifdef APPROX_ADD_ERR_MON_EN
      chk("err_cnt_stream", {16'd0, err_cnt}, 32'd3);
`endif

      // Reset while two transactions are in flight and none has been handed off.
      out_ready = 1'b0;
      a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
      tick();
      a = 16'h0202; b = 16'h0101;
      tick();
      chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
      chk("mr_pre_sum", {15'd0, sum}, 32'h00200);
      rst_n = 1'b0; in_valid = 1'b0;
      tick();
      chk("mr_valid", {31'd0, out_valid}, 32'd0);
      chk("mr_sum", {15'd0, sum}, 32'd0);
`ifdef APPROX_ADD_ERR_MON_EN
      chk("mr_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mr_no_stale", {31'd0, out_valid}, 32'd0);
      end

`ifdef APPROX_ADD_ERR_MON_EN
      // Every one of these results is off by one from the exact sum.
      a = 16'h000F; b = 16'h0001; in_valid = 1'b1;
      repeat (65540) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("err_cnt_sat", {16'd0, err_cnt}, 32'h0000FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
